// File: rtl/rgbw_sotp_gen.sv
// One-wire NRZ LED serialiser: pops pixel words from a synchronous FIFO, optionally
// splits out a white channel, and drives SK6812/WS2812-style bit timing.
module rgbw_sotp_gen #(
  parameter int unsigned T0H           = 16,
  parameter int unsigned T0L           = 74,
  parameter int unsigned T1H           = 45,
  parameter int unsigned T1L           = 45,
  parameter int unsigned RESET_CLKS    = 7681,
  parameter bit          WHITE_EXTRACT = 1'b1,
  parameter int unsigned ORDER         = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_rd_fifo_empty,
  input  logic [31:0] in_rd_fifo_data,
  output logic        out_rd_fifo_en,
  output logic        out_sig,
  output logic        out_busy
);

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int NBITS = WHITE_EXTRACT ? 32 : 24;
  localparam int unsigned T_MAX = umax(umax(umax(RESET_CLKS, T0L), umax(T1H, T1L)), T0H);
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T0H_LD = TW'(T0H - 1);
  localparam logic [TW-1:0] T0L_LD = TW'(T0L - 1);
  localparam logic [TW-1:0] T1H_LD = TW'(T1H - 1);
  localparam logic [TW-1:0] T1L_LD = TW'(T1L - 1);
  localparam logic [TW-1:0] RST_LD = TW'(RESET_CLKS - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT_H, SHIFT_L, STRM_RST} state_t;

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // W is the common floor of the three channels, so the subtractions never wrap.
  function automatic logic [NBITS-1:0] build_frame(input logic [7:0] r, input logic [7:0] g,
                                                   input logic [7:0] b);
    logic [7:0]  w;
    logic [7:0]  rr;
    logic [7:0]  gg;
    logic [7:0]  bb;
    logic [31:0] f;
    w  = min3(r, g, b);
    rr = r;
    gg = g;
    bb = b;
    if (WHITE_EXTRACT) begin
      rr = r - w;
      gg = g - w;
      bb = b - w;
    end
    if (ORDER == 1) f = {gg, rr, bb, w};
    else            f = {rr, gg, bb, w};
    return f[31 -: NBITS];
  endfunction

  state_t           state;
  logic [TW-1:0]    timer;
  logic [5:0]       bit_cnt;
  logic [7:0]       r_p0;
  logic [7:0]       g_p0;
  logic [7:0]       b_p0;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] frame_load;
  logic             unused_fifo_bits;

  assign unused_fifo_bits = ^in_rd_fifo_data[29:24];
  assign frame_load       = build_frame(r_p0, g_p0, b_p0);

  // Stage p0: pixel latch on the FIFO sample cycle, then the output shift register.
  always_ff @(posedge clk) begin
    if (state == POP && !out_rd_fifo_en) begin
      g_p0 <= in_rd_fifo_data[23:16];
      r_p0 <= in_rd_fifo_data[15:8];
      b_p0 <= in_rd_fifo_data[7:0];
    end
    if (state == LOAD) begin
      shreg <= frame_load;
    end else if (state == SHIFT_L && timer == '0) begin
      shreg <= {shreg[NBITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      out_rd_fifo_en <= 1'b0;
      out_sig        <= 1'b0;
      out_busy       <= 1'b0;
      timer          <= '0;
      bit_cnt        <= '0;
    end else begin
      out_rd_fifo_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_rd_fifo_empty) begin
            out_rd_fifo_en <= 1'b1;
            out_busy       <= 1'b1;
            state          <= POP;
          end
        end
        // First POP cycle carries the strobe; the word is valid on the second.
        POP: begin
          if (!out_rd_fifo_en) begin
            if (in_rd_fifo_data[30]) begin
              timer <= RST_LD;
              state <= STRM_RST;
            end else if (!in_rd_fifo_data[31]) begin
              out_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          bit_cnt <= 6'(NBITS);
          timer   <= frame_load[NBITS-1] ? T1H_LD : T0H_LD;
          out_sig <= 1'b1;
          state   <= SHIFT_H;
        end
        SHIFT_H: begin
          if (timer == '0) begin
            out_sig <= 1'b0;
            timer   <= shreg[NBITS-1] ? T1L_LD : T0L_LD;
            state   <= SHIFT_L;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        SHIFT_L: begin
          if (timer == '0) begin
            bit_cnt <= bit_cnt - 6'd1;
            if (bit_cnt != 6'd1) begin
              out_sig <= 1'b1;
              timer   <= shreg[NBITS-2] ? T1H_LD : T0H_LD;
              state   <= SHIFT_H;
            end else begin
              out_busy <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STRM_RST: begin
          if (timer == '0) begin
            out_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          out_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_sotp_gen.sv
// Bench for rgbw_sotp_gen: an RGBW/ORDER=0 instance and an RGB/ORDER=1 instance fed
// from queue FIFOs, with line timing decoded and compared against a pixel-level model.
module tb_rgbw_sotp_gen;
  localparam int RST_CLKS = 7681;
  localparam int LOGN     = 1024;
  localparam int POPN     = 64;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic [1:0]  empty  = 2'b11;
  logic [31:0] rdata0 = '0;
  logic [31:0] rdata1 = '0;
  logic [1:0]  en;
  logic [1:0]  sig;
  logic [1:0]  busy;

  logic [31:0] fq0 [$];
  logic [31:0] fq1 [$];

  int         cyc           = 0;
  int         rd_empty_viol = 0;
  int         dbl_en_viol   = 0;
  logic [1:0] en_q          = 2'b00;
  logic [1:0] sig_q         = 2'b00;
  logic [1:0] busy_q        = 2'b00;

  int rise_t [2][LOGN];
  int fall_t [2][LOGN];
  int pop_t  [2][POPN];
  int idle_t [2][POPN];
  int n_rise [2] = '{0, 0};
  int n_fall [2] = '{0, 0};
  int n_pop  [2] = '{0, 0};
  int n_idle [2] = '{0, 0};

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] wq [16];
  int          nw;
  int          g_br;
  int          g_bf;

  always #5 clk = ~clk;

  rgbw_sotp_gen #(.WHITE_EXTRACT(1'b1), .ORDER(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_rd_fifo_empty(empty[0]), .in_rd_fifo_data(rdata0),
    .out_rd_fifo_en(en[0]), .out_sig(sig[0]), .out_busy(busy[0]));

  rgbw_sotp_gen #(.WHITE_EXTRACT(1'b0), .ORDER(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_rd_fifo_empty(empty[1]), .in_rd_fifo_data(rdata1),
    .out_rd_fifo_en(en[1]), .out_sig(sig[1]), .out_busy(busy[1]));

  // Synchronous-read FIFO models: data appears the cycle after the strobe.
  always @(posedge clk) begin
    int ve;
    int vd;
    ve = 0;
    vd = 0;
    if (en[0]) begin
      if (fq0.size() == 0) ve++;
      else rdata0 <= fq0.pop_front();
    end
    if (en[1]) begin
      if (fq1.size() == 0) ve++;
      else rdata1 <= fq1.pop_front();
    end
    if (en[0] && en_q[0]) vd++;
    if (en[1] && en_q[1]) vd++;
    rd_empty_viol <= rd_empty_viol + ve;
    dbl_en_viol   <= dbl_en_viol + vd;
    en_q          <= en;
    empty         <= {fq1.size() == 0, fq0.size() == 0};
    cyc           <= cyc + 1;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        if (sig[d] && !sig_q[d] && n_rise[d] < LOGN) begin
          rise_t[d][n_rise[d]] = cyc;
          n_rise[d] = n_rise[d] + 1;
        end
        if (!sig[d] && sig_q[d] && n_fall[d] < LOGN) begin
          fall_t[d][n_fall[d]] = cyc;
          n_fall[d] = n_fall[d] + 1;
        end
        if (en[d] && n_pop[d] < POPN) begin
          pop_t[d][n_pop[d]] = cyc;
          n_pop[d] = n_pop[d] + 1;
        end
        if (!busy[d] && busy_q[d] && n_idle[d] < POPN) begin
          idle_t[d][n_idle[d]] = cyc;
          n_idle[d] = n_idle[d] + 1;
        end
      end
      sig_q[d]  = sig[d];
      busy_q[d] = busy[d];
    end
  end

  // Expected bit stream for one valid pixel word on instance d.
  function automatic void ref_frame(input int d, input logic [31:0] w,
                                    output logic [31:0] e, output int nb);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] m;
    g = w[23:16];
    r = w[15:8];
    b = w[7:0];
    m = r;
    if (g < m) m = g;
    if (b < m) m = b;
    if (d == 0) begin
      e  = {r - m, g - m, b - m, m};
      nb = 32;
    end else begin
      e  = {8'h00, g, r, b};
      nb = 24;
    end
  endfunction

  function automatic int fsize(input int d);
    return (d == 0) ? fq0.size() : fq1.size();
  endfunction

  task automatic run_words(input int d, input string tag);
    int          br, bf, bp, bi, budget, k, roff, p, it, nb, h, l, eh, el, terr, th, tl;
    logic [31:0] e;
    logic [31:0] val;
    br     = n_rise[d];
    bf     = n_fall[d];
    bp     = n_pop[d];
    bi     = n_idle[d];
    g_br   = br;
    g_bf   = bf;
    budget = 50;
    for (int j = 0; j < nw; j++) begin
      budget += wq[j][30] ? RST_CLKS + 10 : 32 * 90 + 10;
      if (d == 0) fq0.push_back(wq[j]);
      else fq1.push_back(wq[j]);
    end
    k = 0;
    while (k < budget && !((n_idle[d] - bi) >= nw && fsize(d) == 0 && !busy[d])) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      failures++;
      $display("FAIL %s_timeout: waited %0d cycles, limit %0d", tag, k, budget);
    end
    roff = 0;
    for (int j = 0; j < nw; j++) begin
      p  = pop_t[d][bp + j];
      it = idle_t[d][bi + j];
      if (wq[j][30]) begin
        checks++;
        if (it - p !== RST_CLKS + 2) begin
          failures++;
          $display("FAIL %s_strm_busy w%0d: got %0d required %0d", tag, j, it - p, RST_CLKS + 2);
        end
      end else if (!wq[j][31]) begin
        checks++;
        if (it - p !== 2) begin
          failures++;
          $display("FAIL %s_discard_busy w%0d: got %0d required 2", tag, j, it - p);
        end
      end else begin
        ref_frame(d, wq[j], e, nb);
        checks++;
        if (rise_t[d][br + roff] - p !== 3) begin
          failures++;
          $display("FAIL %s_first_rise w%0d: got %0d required 3", tag, j,
                   rise_t[d][br + roff] - p);
        end
        val  = '0;
        terr = -1;
        th   = 0;
        tl   = 0;
        for (int i = 0; i < nb; i++) begin
          h  = fall_t[d][bf + roff + i] - rise_t[d][br + roff + i];
          l  = (i < nb - 1) ? rise_t[d][br + roff + i + 1] - fall_t[d][bf + roff + i]
                            : it - fall_t[d][bf + roff + i];
          eh = e[nb - 1 - i] ? 45 : 16;
          el = e[nb - 1 - i] ? 45 : 74;
          val = {val[30:0], (h > 30)};
          if ((h != eh || l != el) && terr < 0) begin
            terr = i;
            th   = h;
            tl   = l;
          end
        end
        checks++;
        if (val !== e) begin
          failures++;
          $display("FAIL %s_bits w%0d: got %h required %h", tag, j, val, e);
        end
        checks++;
        if (terr >= 0) begin
          failures++;
          $display("FAIL %s_bit_timing w%0d bit %0d: got %0d/%0d high/low", tag, j, terr, th, tl);
        end
        roff += nb;
      end
      if (j + 1 < nw) begin
        checks++;
        if (pop_t[d][bp + j + 1] !== it + 1) begin
          failures++;
          $display("FAIL %s_next_pop w%0d: got %0d required %0d", tag, j,
                   pop_t[d][bp + j + 1], it + 1);
        end
      end
    end
    checks++;
    if (n_pop[d] - bp !== nw) begin
      failures++;
      $display("FAIL %s_pop_count: got %0d required %0d", tag, n_pop[d] - bp, nw);
    end
    checks++;
    if (n_rise[d] - br !== roff) begin
      failures++;
      $display("FAIL %s_rise_count: got %0d required %0d", tag, n_rise[d] - br, roff);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sig !== 2'b00) begin failures++; $display("FAIL reset_sig: got %b required 00", sig); end
    checks++;
    if (en !== 2'b00) begin failures++; $display("FAIL reset_en: got %b required 00", en); end
    checks++;
    if (busy !== 2'b00) begin failures++; $display("FAIL reset_busy: got %b required 00", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 2'b00 || sig !== 2'b00) begin
      failures++;
      $display("FAIL idle_empty: got busy %b sig %b required 00/00", busy, sig);
    end
    checks++;
    if (n_pop[0] + n_pop[1] !== 0) begin
      failures++;
      $display("FAIL idle_no_pop: got %0d pops required 0", n_pop[0] + n_pop[1]);
    end
  endtask

  task automatic test_white_pixel();
    nw    = 1;
    wq[0] = 32'h80FF8040;
    run_words(0, "white");
  endtask

  task automatic test_stream_reset();
    nw    = 1;
    wq[0] = 32'h40000000;
    run_words(0, "strm");
  endtask

  task automatic test_invalid();
    nw    = 2;
    wq[0] = 32'h00123456;
    wq[1] = 32'h80010203;
    run_words(0, "invalid");
  endtask

  task automatic test_passthrough();
    nw    = 1;
    wq[0] = 32'h80123456;
    run_words(1, "pass");
  endtask

  task automatic test_random(input int d, input int n, input string tag);
    logic [31:0] w;
    nw = n;
    for (int j = 0; j < n; j++) begin
      w     = $urandom;
      w[31] = ($urandom_range(0, 4) != 0);
      w[30] = 1'b0;
      wq[j] = w;
    end
    wq[0] = 32'h80FFFFFF;
    wq[1] = 32'h80000000;
    run_words(d, tag);
  endtask

  task automatic test_reset_midframe();
    int br;
    int k;
    br = n_rise[0];
    fq0.push_back(32'h80A5C33C);
    k = 0;
    while (n_rise[0] < br + 10 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 2000) begin failures++; $display("FAIL midrst_wait: got %0d cycles", k); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sig[0] !== 1'b0) begin failures++; $display("FAIL midrst_sig: got %b required 0", sig[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy[0]); end
    checks++;
    if (en[0] !== 1'b0) begin failures++; $display("FAIL midrst_en: got %b required 0", en[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sig[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abandon: got sig %b busy %b required 0/0", sig[0], busy[0]);
    end
    nw    = 1;
    wq[0] = 32'h8055AA0F;
    run_words(0, "midrst_next");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int          nb;
    int          gap;
    nw    = 3;
    wq[0] = {8'h80, 24'($urandom)};
    wq[1] = {8'h80, 24'($urandom)};
    wq[2] = 32'h40000000;
    run_words(0, "b2b");
    ref_frame(0, wq[0], e, nb);
    gap = rise_t[0][g_br + 32] - fall_t[0][g_bf + 31];
    checks++;
    if (gap !== (e[0] ? 45 : 74) + 4) begin
      failures++;
      $display("FAIL b2b_gap: got %0d required %0d", gap, (e[0] ? 45 : 74) + 4);
    end
  endtask

  initial begin
    test_reset();
    test_white_pixel();
    test_stream_reset();
    test_invalid();
    test_passthrough();
    test_random(0, 4, "rand_w");
    test_random(1, 3, "rand_p");
    test_reset_midframe();
    test_back_to_back();
    checks++;
    if (rd_empty_viol !== 0) begin
      failures++;
      $display("FAIL read_while_empty: got %0d required 0", rd_empty_viol);
    end
    checks++;
    if (dbl_en_viol !== 0) begin
      failures++;
      $display("FAIL double_strobe: got %0d required 0", dbl_en_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
